// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants for the instruction-fetch stage.
package fetch_pkg;
    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [PC_WIDTH-1:0] PC_INC = 32'd4;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = 32'h0000_0003;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: control, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_stage_if;
    import fetch_pkg::*;
    logic                stall;
    logic                flush;
    logic                br_taken;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_data;
    logic [31:0]         if_id_instr;
    logic [PC_WIDTH-1:0] if_id_npc;
    logic                if_id_valid;
    modport master (
        input  stall, flush, br_taken, br_target, imem_data,
        output imem_addr, if_id_instr, if_id_npc, if_id_valid
    );
    modport slave (
        output stall, flush, br_taken, br_target, imem_data,
        input  imem_addr, if_id_instr, if_id_npc, if_id_valid
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and flush-to-bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic [31:0]         instr_next,
    input  logic [PC_WIDTH-1:0] npc_next,
    output logic [31:0]         instr,
    output logic [PC_WIDTH-1:0] npc,
    output logic                valid
);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr <= NOP_INSTR;
            npc   <= '0;
            valid <= 1'b0;
        end else if (!stall) begin
            instr <= instr_next;
            npc   <= npc_next;
            valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC mux and IF/ID capture.
// Define FETCH_PERF_EN to add the perf_fetch_cnt/perf_stall_cnt counters.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_next;

    assign pc_inc = pc + PC_INC;
    // redirect beats stall; low target bits are dropped rather than trapped
    always_comb pc_next = rst           ? RESET_PC :
                          bus.br_taken  ? (bus.br_target & ~ALIGN_MASK) :
                          bus.stall     ? pc : pc_inc;

    always_ff @(posedge clk) pc <= pc_next;

    assign bus.imem_addr = pc;

    if_id_reg u_if_id (
        .clk        (clk),
        .rst        (rst),
        .stall      (bus.stall),
        .flush      (bus.flush),
        .instr_next (bus.imem_data),
        .npc_next   (pc_inc),
        .instr      (bus.if_id_instr),
        .npc        (bus.if_id_npc),
        .valid      (bus.if_id_valid)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (!bus.flush && !bus.stall)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (bus.stall && !bus.flush && !bus.br_taken)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of PC sequencing, stall, flush, redirect, wrap and reset.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [31:0] mem [64];
    logic [96:0] obs, exp_v;
    fetch_stage_if bus();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    logic [31:0] stall_base;
`endif

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign bus.imem_data = mem[bus.imem_addr[7:2]];
    assign obs = {bus.imem_addr, bus.if_id_instr, bus.if_id_npc, bus.if_id_valid};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        step(); step();
        exp_v = {32'h0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp_v); end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
            failures++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        step();
        exp_v = {32'h4, 32'hA00000AA, 32'h4, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL free_run_w0 got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = {32'h8, 32'h10000011, 32'h8, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL free_run_w1 got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_stall();
`ifdef FETCH_PERF_EN
        stall_base = perf_stall_cnt;
`endif
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            exp_v = {32'h8, 32'h10000011, 32'h8, 1'b1};
            checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs, exp_v); end
        end
`ifdef FETCH_PERF_EN
        checks++;
        if (perf_stall_cnt - stall_base !== 32'd3) begin
            failures++; $display("FAIL stall_perf got=%0d exp=3", perf_stall_cnt - stall_base);
        end
`endif
        bus.stall = 1'b0;
        step();
        exp_v = {32'hC, 32'h20000022, 32'hC, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL stall_release got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_branch_flush();
        bus.br_taken = 1'b1; bus.br_target = 32'h0000_0013; bus.flush = 1'b1;
        step();
        idle();
        exp_v = {32'h10, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL branch_bubble got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = {32'h14, 32'h40000044, 32'h14, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL branch_target got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_branch_stall();
        bus.br_taken = 1'b1; bus.br_target = 32'h20; bus.stall = 1'b1;
        step();
        idle();
        exp_v = {32'h20, 32'h40000044, 32'h14, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL br_stall got=%h exp=%h", obs, exp_v); end
        bus.flush = 1'b1; bus.stall = 1'b1;
        step();
        idle();
        exp_v = {32'h20, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL flush_stall got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = {32'h24, 32'h80000088, 32'h24, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL after_flush got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_wrap();
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        step();
        idle();
        exp_v = {32'hFFFFFFFC, 32'h90000099, 32'h28, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wrap_redirect got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = {32'h0, 32'hF00000FF, 32'h0, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL wrap_pc got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        step();
        rst = 1'b1; bus.stall = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h40;
        step();
        rst = 1'b0; idle();
        exp_v = {32'h0, 32'h0, 32'h0, 1'b0};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rst_mid got=%h exp=%h", obs, exp_v); end
`ifdef FETCH_PERF_EN
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
            failures++; $display("FAIL rst_mid_perf got=%h/%h exp=0/0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        step();
        exp_v = {32'h4, 32'hA00000AA, 32'h4, 1'b1};
        checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL rst_refetch got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | i;
        mem[0] = 32'hA00000AA; mem[1] = 32'h10000011; mem[2] = 32'h20000022;
        mem[3] = 32'h30000033; mem[4] = 32'h40000044; mem[8] = 32'h80000088;
        mem[9] = 32'h90000099; mem[63] = 32'hF00000FF;
        test_reset();
        test_free_run();
        test_stall();
        test_branch_flush();
        test_branch_stall();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: holds the program counter, drives the byte address into the combinational instruction memory, and captures the returned word with its PC+4 into the IF/ID pipeline register. Sits between the EX/MEM branch-resolution logic (redirect source), the hazard unit (stall/flush source), and the decode stage (consumer of IF/ID).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush/reset (sll $0,$0,0)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold PC and IF/ID this cycle (load-use hazard)
- flush  in  1  replace IF/ID contents with bubble this cycle
- br_taken  in  1  redirect PC to br_target this cycle
- br_target  in  32  byte address of redirect target
- imem_addr  out  32  byte address to instruction memory (equals PC)
- imem_data  in  32  instruction word returned combinationally for imem_addr
- if_id_instr  out  32  latched instruction
- if_id_npc  out  32  latched PC+4 of that instruction
- if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
- perf_fetch_cnt  out  32  instructions accepted into IF/ID (FETCH_PERF_EN only)
- perf_stall_cnt  out  32  cycles with stall asserted and not overridden (FETCH_PERF_EN only)

## Operation
- pc register drives imem_addr directly; memory read is combinational, so instruction at pc is available same cycle.
- Next-PC selection, priority high to low: rst -> RESET_PC; br_taken -> {br_target[31:2],2'b00}; stall -> pc (hold); else pc+4.
- IF/ID update, priority high to low: rst or flush -> instr=NOP_INSTR, npc=0, valid=0; stall -> hold all three; else instr=imem_data, npc=pc+4, valid=1.
- br_taken does not itself flush IF/ID; the hazard unit asserts flush in the same cycle when squashing is required.
- br_taken with stall: PC takes br_target (redirect beats stall); IF/ID holds unless flush also asserted.
- flush with stall: IF/ID becomes bubble; PC holds unless br_taken.
- pc+4 is 32-bit modulo: 0xFFFF_FFFC wraps to 0x0000_0000, no flag.
- br_target[1:0] are discarded; no misalignment trap.
- No address range check; memory aliases above its depth, fetch is unaware.

## Timing
- Reset values: pc=RESET_PC, imem_addr=RESET_PC, if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0, perf counters=0.
- Fetch latency: instruction at pc appears on if_id_instr one clock after pc is presented.
- Redirect latency: br_taken at edge N -> imem_addr=target after edge N; target instruction in IF/ID after edge N+1.
- rst mid-operation: all state returns to reset values at that edge regardless of stall/flush/br_taken; first real fetch from RESET_PC lands in IF/ID one edge after rst deasserts.
- All outputs registered except imem_addr (direct from pc register, no combinational path from inputs).

## Configuration
- FETCH_PERF_EN defined: perf_fetch_cnt increments on every edge that loads IF/ID with valid=1; perf_stall_cnt increments on every edge where stall=1 and neither rst, flush nor br_taken is asserted. Both wrap modulo 2^32, cleared by rst.
- FETCH_PERF_EN undefined: both ports and counters absent; no other behavioural change.

## Structure
- fetch_pkg: RESET_PC default, NOP_INSTR constant, PC_WIDTH=32, PC_INC=4.
- One sub-module: if_id_reg (instr/npc/valid register with hold and flush-to-bubble controls); PC register and next-PC mux stay in fetch_stage.

## Test plan
- Reset then free-run, memory word0=0xA00000AA, word1=0x10000011: imem_addr 0,4,8; IF/ID shows 0xA00000AA/npc 4/valid 1, then 0x10000011/npc 8.
- stall held 3 cycles at pc=0x8: imem_addr stays 0x8, IF/ID unchanged 3 cycles, perf_stall_cnt +3 (with FETCH_PERF_EN).
- br_taken=1, br_target=0x0000_0013 plus flush at pc=0xC: imem_addr=0x10 next cycle, IF/ID bubble (valid 0, instr NOP_INSTR), then word4 0x40000044 with npc 0x14.
- br_taken and stall together, target 0x20: pc loads 0x20, IF/ID held; flush+stall without br_taken: pc held, IF/ID bubble.
- br_target=0xFFFF_FFFC then free-run: imem_addr wraps to 0x0000_0000, if_id_npc=0x0000_0000.
- rst asserted mid-stream with stall=1 and br_taken=1: next edge pc=RESET_PC, IF/ID bubble, perf counters 0.
